// File: rtl/mem_stage_ctrl.sv
// Pipeline memory stage: word-addressed data RAM with fixed multi-cycle access latency and MEM/WB register.
// Optional `define MEM_RANGE_CHECK_EN drops/zeroes out-of-window accesses and flags them on mem_err.
module mem_stage_ctrl #(
  parameter int DEPTH     = 64,
  parameter int ADDR_BASE = 1024,
  parameter int LATENCY   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        WB_EN,
  input  logic        MEM_R_EN,
  input  logic        MEM_W_EN,
  input  logic [3:0]  Dest,
  input  logic [31:0] ALU_res,
  input  logic [31:0] Val_Rm,
  output logic        mem_stall,
  output logic        WB_EN_out,
  output logic        MEM_R_EN_out,
  output logic [3:0]  Dest_out,
  output logic [31:0] ALU_res_out,
  output logic [31:0] Mem_data,
  output logic        mem_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(LATENCY - 1);
  localparam logic [31:0]   BASE     = 32'(ADDR_BASE);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            wb_q, wb_d, rd_q, rd_d, err_q, err_d;
  logic [3:0]      dest_q, dest_d;
  logic [31:0]     alu_q, alu_d, md_q, md_d;
  logic [31:0]     mem_q [DEPTH];
  logic [31:0]     off;
  logic [AW-1:0]   idx;
  logic            mem_op, in_rng, done, wr_en;

  // Subtract-then-truncate gives the modulo-DEPTH wrap for free.
  assign off    = ALU_res - BASE;
  assign idx    = AW'(off >> 2);
  assign mem_op = MEM_R_EN | MEM_W_EN;

`ifdef MEM_RANGE_CHECK_EN
  localparam logic [31:0] LIMIT = 32'(ADDR_BASE + 4 * DEPTH);
  assign in_rng = (ALU_res >= BASE) && (ALU_res < LIMIT);
`else
  assign in_rng = 1'b1;
`endif

  assign done      = (state_q == IDLE) ? (mem_op && (LATENCY == 1)) : (cnt_q == CNT_LAST);
  assign mem_stall = mem_op & ~done;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wb_d    = wb_q;
    rd_d    = rd_q;
    dest_d  = dest_q;
    alu_d   = alu_q;
    md_d    = md_q;
    err_d   = 1'b0;
    wr_en   = 1'b0;
    if (done) begin
      state_d = IDLE;
      cnt_d   = '0;
      wb_d    = WB_EN;
      rd_d    = MEM_R_EN;
      dest_d  = Dest;
      alu_d   = ALU_res;
      err_d   = ~in_rng;
      // Load has priority when both enables are set.
      if (MEM_R_EN) md_d  = in_rng ? mem_q[idx] : '0;
      else          wr_en = MEM_W_EN & in_rng;
    end else if (state_q == IDLE && !mem_op) begin
      wb_d   = WB_EN;
      rd_d   = 1'b0;
      dest_d = Dest;
      alu_d  = ALU_res;
    end else begin
      state_d = BUSY;
      cnt_d   = cnt_q + CW'(1);
      wb_d    = 1'b0;
      rd_d    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wb_q    <= 1'b0;
      rd_q    <= 1'b0;
      dest_q  <= '0;
      alu_q   <= '0;
      md_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wb_q    <= wb_d;
      rd_q    <= rd_d;
      dest_q  <= dest_d;
      alu_q   <= alu_d;
      md_q    <= md_d;
      err_q   <= err_d;
    end
  end

  // Memory contents survive reset; an aborted store never commits.
  always_ff @(posedge clk) begin
    if (!rst && wr_en) mem_q[idx] <= Val_Rm;
  end

  assign WB_EN_out    = wb_q;
  assign MEM_R_EN_out = rd_q;
  assign Dest_out     = dest_q;
  assign ALU_res_out  = alu_q;
  assign Mem_data     = md_q;
  assign mem_err      = err_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Self-checking bench for mem_stage_ctrl: vector table, reset/abort and LATENCY=1 sequences, random ops vs reference model.
module tb_mem_stage_ctrl;
  localparam int DEPTH = 64;
  localparam int BASE  = 1024;
  localparam int LAT   = 4;
`ifdef MEM_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, wb, re, we;
  logic [3:0]  dest;
  logic [31:0] alu, val;
  logic        stall, wbo, reo, err;
  logic [3:0]  desto;
  logic [31:0] aluo, md;

  logic        l_wb, l_re, l_we;
  logic [3:0]  l_dest;
  logic [31:0] l_alu, l_val;
  logic        l_stall, l_wbo, l_reo, l_err;
  logic [3:0]  l_desto;
  logic [31:0] l_aluo, l_md;

  mem_stage_ctrl #(.DEPTH(DEPTH), .ADDR_BASE(BASE), .LATENCY(LAT)) u_dut (
    .clk(clk), .rst(rst), .WB_EN(wb), .MEM_R_EN(re), .MEM_W_EN(we), .Dest(dest),
    .ALU_res(alu), .Val_Rm(val), .mem_stall(stall), .WB_EN_out(wbo), .MEM_R_EN_out(reo),
    .Dest_out(desto), .ALU_res_out(aluo), .Mem_data(md), .mem_err(err));

  mem_stage_ctrl #(.DEPTH(DEPTH), .ADDR_BASE(BASE), .LATENCY(1)) u_l1 (
    .clk(clk), .rst(rst), .WB_EN(l_wb), .MEM_R_EN(l_re), .MEM_W_EN(l_we), .Dest(l_dest),
    .ALU_res(l_alu), .Val_Rm(l_val), .mem_stall(l_stall), .WB_EN_out(l_wbo), .MEM_R_EN_out(l_reo),
    .Dest_out(l_desto), .ALU_res_out(l_aluo), .Mem_data(l_md), .mem_err(l_err));

  int checks = 0, failures = 0;

  // Reference model: memory image plus the expected MEM/WB register contents.
  logic [31:0] mdl_mem [DEPTH];
  logic        exp_wb, exp_re, exp_err;
  logic [3:0]  exp_dest;
  logic [31:0] exp_alu, exp_md;

  typedef struct {
    logic        w, r, b;
    logic [3:0]  d;
    logic [31:0] a, v, exp_md;
    logic        exp_err;
  } vec_t;
  vec_t tbl [9];

  function automatic vec_t mk(logic w, logic r, logic b, logic [3:0] d, logic [31:0] a,
                              logic [31:0] v, logic [31:0] emd, logic eerr);
    vec_t t;
    t.w = w; t.r = r; t.b = b; t.d = d; t.a = a; t.v = v; t.exp_md = emd; t.exp_err = eerr;
    return t;
  endfunction

  function automatic bit in_rng(logic [31:0] a);
    return !RC || (a >= 32'(BASE) && a < 32'(BASE + 4 * DEPTH));
  endfunction

  function automatic int widx(logic [31:0] a);
    logic [31:0] d;
    d = a - 32'(BASE);
    return int'((d / 4) % DEPTH);
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_regs();
    check("WB_EN_out", 32'(wbo), 32'(exp_wb));
    check("MEM_R_EN_out", 32'(reo), 32'(exp_re));
    check("Dest_out", 32'(desto), 32'(exp_dest));
    check("ALU_res_out", aluo, exp_alu);
    check("Mem_data", md, exp_md);
    check("mem_err", 32'(err), 32'(exp_err));
  endtask

  // Issue one op, hold it while stalled, and check every cycle against the model.
  task automatic do_op(input logic w, input logic r, input logic b, input logic [3:0] d,
                       input logic [31:0] a, input logic [31:0] v);
    int n;
    n = (w | r) ? LAT : 1;
    wb = b; re = r; we = w; dest = d; alu = a; val = v;
    for (int k = 0; k < n; k++) begin
      #1;
      check("mem_stall", 32'(stall), 32'(k < n - 1));
      @(posedge clk); #1;
      if (k < n - 1) begin
        exp_wb = 1'b0; exp_re = 1'b0; exp_err = 1'b0;
      end else begin
        exp_wb = b; exp_re = r; exp_dest = d; exp_alu = a;
        exp_err = (w | r) && !in_rng(a);
        if (r) exp_md = in_rng(a) ? mdl_mem[widx(a)] : 32'h0;
        else if (w && in_rng(a)) mdl_mem[widx(a)] = v;
      end
      check_regs();
    end
  endtask

  initial begin
    logic [31:0] a, v;
    int t;
    rst = 1'b1; wb = 0; re = 0; we = 0; dest = 0; alu = 0; val = 0;
    l_wb = 0; l_re = 0; l_we = 0; l_dest = 0; l_alu = 0; l_val = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_wb = 0; exp_re = 0; exp_err = 0; exp_dest = 0; exp_alu = 0; exp_md = 0;
    check_regs();
    check("reset_stall", 32'(stall), 32'h0);
    check("l1_reset_md", l_md, 32'h0);

    for (int i = 0; i < DEPTH; i++) do_op(1'b1, 1'b0, 1'b0, 4'd0, 32'(BASE + 4 * i), 32'hA500_0000 | 32'(i));

    tbl[0] = mk(0, 0, 1, 4'd3, 32'h55,  32'h0,         32'h0,                              1'b0);
    tbl[1] = mk(1, 0, 0, 4'd0, 32'd1032, 32'hDEADBEEF, 32'h0,                              1'b0);
    tbl[2] = mk(0, 1, 1, 4'd5, 32'd1032, 32'h0,        32'hDEADBEEF,                       1'b0);
    tbl[3] = mk(0, 1, 1, 4'd6, 32'd1280, 32'h0,        RC ? 32'h0 : 32'hA500_0000,         RC);
    tbl[4] = mk(1, 1, 1, 4'd7, 32'd1036, 32'hBAD0BAD0, 32'hA500_0003,                      1'b0);
    tbl[5] = mk(0, 1, 1, 4'd8, 32'd1036, 32'h0,        32'hA500_0003,                      1'b0);
    tbl[6] = mk(0, 1, 1, 4'd9, 32'd1043, 32'h0,        32'hA500_0004,                      1'b0);
    tbl[7] = mk(1, 0, 0, 4'd0, 32'd1020, 32'h7777_7777, 32'hA500_0004,                     RC);
    tbl[8] = mk(0, 1, 1, 4'd1, 32'd1276, 32'h0,        RC ? 32'hA500_003F : 32'h7777_7777, 1'b0);
    for (int i = 0; i < 9; i++) begin
      do_op(tbl[i].w, tbl[i].r, tbl[i].b, tbl[i].d, tbl[i].a, tbl[i].v);
      check($sformatf("tbl%0d_md", i), md, tbl[i].exp_md);
      check($sformatf("tbl%0d_err", i), 32'(err), 32'(tbl[i].exp_err));
    end

    // Store aborted by reset in its second BUSY cycle must not commit.
    wb = 0; re = 0; we = 1; dest = 4'd4; alu = 32'd1044; val = 32'h1111_1111;
    #1 check("abort_stall", 32'(stall), 32'h1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; we = 0; dest = 0; alu = 0; val = 0;
    exp_wb = 0; exp_re = 0; exp_err = 0; exp_dest = 0; exp_alu = 0; exp_md = 0;
    check_regs();
    #1 check("abort_idle_stall", 32'(stall), 32'h0);
    do_op(1'b0, 1'b1, 1'b1, 4'd2, 32'd1044, 32'h0);
    check("abort_old_data", md, 32'hA500_0005);

    // Single-cycle instance: alternating store/load never stalls.
    for (int i = 0; i < 4; i++) begin
      v = 32'h1234_5678 + 32'(i) * 32'h0101_0101;
      l_we = 1; l_re = 0; l_wb = 0; l_dest = 0; l_alu = 32'd1028; l_val = v;
      #1 check("l1_st_stall", 32'(l_stall), 32'h0);
      @(posedge clk); #1;
      check("l1_st_wb", 32'(l_wbo), 32'h0);
      l_we = 0; l_re = 1; l_wb = 1; l_dest = 4'(i);
      #1 check("l1_ld_stall", 32'(l_stall), 32'h0);
      @(posedge clk); #1;
      check("l1_ld_md", l_md, v);
      check("l1_ld_re", 32'(l_reo), 32'h1);
      check("l1_ld_dest", 32'(l_desto), 32'(i));
      check("l1_ld_err", 32'(l_err), 32'h0);
    end
    l_we = 0; l_re = 0; l_wb = 0;

    for (int i = 0; i < 300; i++) begin
      t = $urandom_range(0, 9);
      a = ($urandom_range(0, 7) == 0) ? $urandom
                                      : 32'(BASE + 4 * $urandom_range(0, DEPTH - 1) + $urandom_range(0, 3));
      v = $urandom;
      if (t < 4)      do_op(1'b0, 1'b0, 1'($urandom), 4'($urandom), a, v);
      else if (t < 7) do_op(1'b1, 1'b0, 1'b0, 4'($urandom), a, v);
      else if (t < 9) do_op(1'b0, 1'b1, 1'b1, 4'($urandom), a, v);
      else            do_op(1'b1, 1'b1, 1'b1, 4'($urandom), a, v);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
